mips_multi_ctl_ws: RTL and testbench

// Next-generation multicycle MIPS controller, drop-in for the mips_multi controller slot.
// - Adds memory wait states (fixed-count or ready-handshake) and optional addi/j/bne support.
// - Adds an illegal-opcode flag.
// - Drives the existing datapath control pins unchanged; core wrappers add only mem_req/mem_ready.

---
 rtl/mips_multi_ctl_ws_if.sv | 34 +++
 rtl/mips_multi_ctl_ws.sv | 195 +++++++++++++++++++
 tb/tb_mips_multi_ctl_ws.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_multi_ctl_ws_if.sv
// rtl/mips_multi_ctl_ws_if.sv - control/status bundle between the multicycle controller and its datapath
interface mips_multi_ctl_ws_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  // controller side
  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal
  );

  // datapath / memory side
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord,
           memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal
  );
endinterface

// File: rtl/mips_multi_ctl_ws.sv
// rtl/mips_multi_ctl_ws.sv - multicycle MIPS controller with memory wait states and extended opcodes
module mips_multi_ctl_ws #(
  parameter bit HANDSHAKE = 1'b0,
  parameter int MEM_WAIT  = 0,
  parameter bit EXT_OPS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_multi_ctl_ws_if.master        bus
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(MEM_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_ALUWB, S_BEQEX, S_BNEEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_access;
  logic          w_done;
  logic [1:0]    w_aluop;
  logic          w_alu_act;
  logic          w_fn_ok;
  logic [2:0]    w_fn_alu;

  // access states and their completion; held low while reset is asserted
  always_comb begin
    w_access = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    w_done   = reset && w_access && (HANDSHAKE ? bus.mem_ready : (r_cnt == W_LAST));
  end

  // wait-state counter: zero on entry to an access state, counts until completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (!w_access || w_done)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_FETCH;
    else
      r_state <= w_next;
  end

  // R-type funct decode
  always_comb begin
    w_fn_ok  = 1'b1;
    w_fn_alu = 3'b000;
    case (bus.funct)
      6'b100000: w_fn_alu = 3'b010;
      6'b100010: w_fn_alu = 3'b110;
      6'b100100: w_fn_alu = 3'b000;
      6'b100101: w_fn_alu = 3'b001;
      6'b101010: w_fn_alu = 3'b111;
      default:   w_fn_ok  = 1'b0;
    endcase
  end

  // next state and Moore/qualified control outputs
  always_comb begin
    w_next       = r_state;
    w_aluop      = 2'b00;
    w_alu_act    = 1'b0;
    bus.mem_req  = 1'b0;
    bus.pcen     = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = 2'b01;
        w_alu_act   = 1'b1;
        if (w_done) begin
          bus.irwrite = 1'b1;
          bus.pcen    = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        w_alu_act   = 1'b1;
        w_next      = S_FETCH;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      if (EXT_OPS) w_next = S_ADDIEX; else bus.illegal = 1'b1;
          OP_J:         if (EXT_OPS) w_next = S_JEX;    else bus.illegal = 1'b1;
          OP_BNE:       if (EXT_OPS) w_next = S_BNEEX;  else bus.illegal = 1'b1;
          default:      bus.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        w_alu_act   = 1'b1;
        w_next      = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord    = 1'b1;
        bus.mem_req = 1'b1;
        if (w_done) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.memwrite = 1'b1;
        if (w_done) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        bus.alusrca = 1'b1;
        w_aluop     = 2'b10;
        w_alu_act   = 1'b1;
        if (w_fn_ok) begin
          w_next = S_ALUWB;
        end else begin
          bus.illegal = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        w_next       = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        bus.alusrca = 1'b1;
        bus.pcsrc   = 2'b01;
        w_aluop     = 2'b01;
        w_alu_act   = 1'b1;
        bus.pcen    = (r_state == S_BEQEX) ? bus.zero : ~bus.zero;
        w_next      = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        w_alu_act   = 1'b1;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.regwrite = 1'b1;
        w_next       = S_FETCH;
      end
      S_JEX: begin
        bus.pcsrc = 2'b10;
        bus.pcen  = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // ALU control: driven only in states that use the ALU, zero elsewhere and in reset
  always_comb begin
    bus.alucontrol = 3'b000;
    if (w_alu_act && reset) begin
      case (w_aluop)
        2'b00:   bus.alucontrol = 3'b010;
        2'b01:   bus.alucontrol = 3'b110;
        default: bus.alucontrol = w_fn_alu;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi_ctl_ws.sv
// tb/tb_mips_multi_ctl_ws.sv - directed bench for mips_multi_ctl_ws in three memory-timing configurations
module tb_mips_multi_ctl_ws;

  logic clk = 1'b0;
  logic rst_w0 = 1'b0;
  logic rst_w2 = 1'b0;
  logic rst_hs = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mips_multi_ctl_ws_if if_w0 ();
  mips_multi_ctl_ws_if if_w2 ();
  mips_multi_ctl_ws_if if_hs ();

  mips_multi_ctl_ws #(.HANDSHAKE(1'b0), .MEM_WAIT(0), .EXT_OPS(1'b1)) u_w0 (
    .clk(clk), .reset(rst_w0), .bus(if_w0));
  mips_multi_ctl_ws #(.HANDSHAKE(1'b0), .MEM_WAIT(2), .EXT_OPS(1'b1)) u_w2 (
    .clk(clk), .reset(rst_w2), .bus(if_w2));
  mips_multi_ctl_ws #(.HANDSHAKE(1'b1), .MEM_WAIT(0), .EXT_OPS(1'b1)) u_hs (
    .clk(clk), .reset(rst_hs), .bus(if_hs));

  // {mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal}
  logic [16:0] o_w0, o_w2, o_hs;
  assign o_w0 = {if_w0.mem_req, if_w0.pcen, if_w0.memwrite, if_w0.irwrite, if_w0.regwrite, if_w0.alusrca,
                 if_w0.iord, if_w0.memtoreg, if_w0.regdst, if_w0.alusrcb, if_w0.pcsrc, if_w0.alucontrol, if_w0.illegal};
  assign o_w2 = {if_w2.mem_req, if_w2.pcen, if_w2.memwrite, if_w2.irwrite, if_w2.regwrite, if_w2.alusrca,
                 if_w2.iord, if_w2.memtoreg, if_w2.regdst, if_w2.alusrcb, if_w2.pcsrc, if_w2.alucontrol, if_w2.illegal};
  assign o_hs = {if_hs.mem_req, if_hs.pcen, if_hs.memwrite, if_hs.irwrite, if_hs.regwrite, if_hs.alusrca,
                 if_hs.iord, if_hs.memtoreg, if_hs.regdst, if_hs.alusrcb, if_hs.pcsrc, if_hs.alucontrol, if_hs.illegal};

  function automatic logic [16:0] ex(input logic mreq, pce, mw, irw, rw, asa, iod, m2r, rdst,
                                     input logic [1:0] asb, psrc, input logic [2:0] alc, input logic ill);
    return {mreq, pce, mw, irw, rw, asa, iod, m2r, rdst, asb, psrc, alc, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int dut, input string tag, input logic [16:0] e);
    @(negedge clk);
    case (dut)
      0:       check(tag, {15'd0, o_w0}, {15'd0, e});
      1:       check(tag, {15'd0, o_w2}, {15'd0, e});
      default: check(tag, {15'd0, o_hs}, {15'd0, e});
    endcase
    @(posedge clk);
    #1;
  endtask

  logic [16:0] e_rst, e_fwait, e_fdone, e_dec, e_madr, e_mrd, e_mwb, e_mwr;
  logic [16:0] e_radd, e_rsub, e_awb, e_aiex, e_aiwb, e_jex, e_dill, e_rill;
  logic [16:0] e_beq1, e_bne1, e_bne0;

  initial begin
    e_rst   = ex(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 0);
    e_fwait = ex(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    e_fdone = ex(1,1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    e_dec   = ex(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
    e_madr  = ex(0,0,0,0,0,1,0,0,0, 2'b10, 2'b00, 3'b010, 0);
    e_mrd   = ex(1,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 0);
    e_mwb   = ex(0,0,0,0,1,0,0,1,0, 2'b00, 2'b00, 3'b000, 0);
    e_mwr   = ex(1,0,1,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 0);
    e_radd  = ex(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, 0);
    e_rsub  = ex(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b110, 0);
    e_awb   = ex(0,0,0,0,1,0,0,0,1, 2'b00, 2'b00, 3'b000, 0);
    e_aiex  = ex(0,0,0,0,0,1,0,0,0, 2'b10, 2'b00, 3'b010, 0);
    e_aiwb  = ex(0,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
    e_jex   = ex(0,1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0);
    e_dill  = ex(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 1);
    e_rill  = ex(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 1);
    e_beq1  = ex(0,1,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b110, 0);
    e_bne1  = ex(0,0,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b110, 0);
    e_bne0  = ex(0,1,0,0,0,1,0,0,0, 2'b00, 2'b01, 3'b110, 0);

    if_w0.opcode = 6'b0; if_w0.funct = 6'b0; if_w0.zero = 1'b0; if_w0.mem_ready = 1'b0;
    if_w2.opcode = 6'b0; if_w2.funct = 6'b0; if_w2.zero = 1'b0; if_w2.mem_ready = 1'b0;
    if_hs.opcode = 6'b0; if_hs.funct = 6'b0; if_hs.zero = 1'b0; if_hs.mem_ready = 1'b0;

    // reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_w0", {15'd0, o_w0}, {15'd0, e_rst});
    check("rst_w2", {15'd0, o_w2}, {15'd0, e_rst});
    check("rst_hs", {15'd0, o_hs}, {15'd0, e_rst});
    @(posedge clk);
    #1;

    // single-cycle memory: every instruction class
    rst_w0 = 1'b1;
    if_w0.opcode = 6'b100011;
    step(0, "lw_fetch", e_fdone); step(0, "lw_dec", e_dec); step(0, "lw_madr", e_madr);
    step(0, "lw_mrd", e_mrd); step(0, "lw_mwb", e_mwb);
    if_w0.opcode = 6'b000000; if_w0.funct = 6'b100010;
    step(0, "sub_fetch", e_fdone); step(0, "sub_dec", e_dec); step(0, "sub_ex", e_rsub); step(0, "sub_wb", e_awb);
    if_w0.opcode = 6'b000100; if_w0.zero = 1'b1;
    step(0, "beq_fetch", e_fdone); step(0, "beq_dec", e_dec); step(0, "beq_ex_z1", e_beq1);
    if_w0.opcode = 6'b000101;
    step(0, "bne_fetch", e_fdone); step(0, "bne_dec", e_dec); step(0, "bne_ex_z1", e_bne1);
    if_w0.zero = 1'b0;
    step(0, "bne2_fetch", e_fdone); step(0, "bne2_dec", e_dec); step(0, "bne_ex_z0", e_bne0);
    if_w0.opcode = 6'b000010;
    step(0, "j_fetch", e_fdone); step(0, "j_dec", e_dec); step(0, "j_ex", e_jex);
    if_w0.opcode = 6'b001000;
    step(0, "addi_fetch", e_fdone); step(0, "addi_dec", e_dec); step(0, "addi_ex", e_aiex); step(0, "addi_wb", e_aiwb);
    if_w0.opcode = 6'b111111;
    step(0, "ill_fetch", e_fdone); step(0, "ill_dec", e_dill);
    if_w0.opcode = 6'b000000; if_w0.funct = 6'b000000;
    step(0, "fill_fetch", e_fdone); step(0, "fill_dec", e_dec); step(0, "fill_ex", e_rill);
    step(0, "post_ill_fetch", e_fdone);

    // two wait states per access
    rst_w2 = 1'b1;
    if_w2.opcode = 6'b000000; if_w2.funct = 6'b100000;
    step(1, "w2_add_f1", e_fwait); step(1, "w2_add_f2", e_fwait); step(1, "w2_add_f3", e_fdone);
    step(1, "w2_add_dec", e_dec); step(1, "w2_add_ex", e_radd); step(1, "w2_add_wb", e_awb);
    if_w2.opcode = 6'b100011;
    step(1, "w2_lw_f1", e_fwait); step(1, "w2_lw_f2", e_fwait); step(1, "w2_lw_f3", e_fdone);
    step(1, "w2_lw_dec", e_dec); step(1, "w2_lw_madr", e_madr);
    step(1, "w2_lw_mrd1", e_mrd); step(1, "w2_lw_mrd2", e_mrd); step(1, "w2_lw_mrd3", e_mrd);
    step(1, "w2_lw_mwb", e_mwb); step(1, "w2_next_f1", e_fwait);

    // ready handshake
    rst_hs = 1'b1;
    step(2, "hs_fwait1", e_fwait); step(2, "hs_fwait2", e_fwait);
    if_hs.opcode = 6'b101011; if_hs.mem_ready = 1'b1;
    step(2, "hs_sw_fetch", e_fdone); step(2, "hs_sw_dec", e_dec); step(2, "hs_sw_madr", e_madr);
    if_hs.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(2, "hs_sw_wait", e_mwr);
    if_hs.mem_ready = 1'b1;
    step(2, "hs_sw_done", e_mwr);
    if_hs.mem_ready = 1'b0;
    step(2, "hs_next_fwait", e_fwait);
    if_hs.mem_ready = 1'b1;
    step(2, "hs_sw2_fetch", e_fdone); step(2, "hs_sw2_dec", e_dec); step(2, "hs_sw2_madr", e_madr);
    if_hs.mem_ready = 1'b0;
    step(2, "hs_sw2_wait1", e_mwr);
    #2;
    rst_hs = 1'b0;
    #1;
    check("hs_rst_memwrite", {31'd0, if_hs.memwrite}, 32'd0);
    check("hs_rst_async", {15'd0, o_hs}, {15'd0, e_rst});
    @(posedge clk);
    #1;
    rst_hs = 1'b1;
    if_hs.mem_ready = 1'b1;
    step(2, "hs_post_rst_fetch", e_fdone);
    step(2, "hs_post_rst_dec", e_dec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
